fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 44 ++++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_buffer.sv | 70 +++++++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               the bubble instruction, the fetch FSM states, the IF/ID
//               payload and the instruction buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } buf_entry_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  function automatic ifid_t make_ifid(input logic [31:0] instr,
                                      input logic [31:0] pc,
                                      input logic        valid);
    ifid_t r;
    r.instr    = instr;
    r.pc       = pc;
    r.pc_plus4 = pc + 32'd4;
    r.valid    = valid;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction memory request/response bus.
//               master : fetch unit (drives req/addr, receives gnt/rvalid/rdata)
//               slave  : instruction memory
//   imem_req_o    : request
//   imem_addr_o   : word-aligned fetch address
//   imem_gnt_i    : request accepted this cycle
//   imem_rvalid_i : in-order response valid
//   imem_rdata_i  : instruction word
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : 2-entry in-order buffer of {instr, pc} between the memory
//               response and the IF/ID register.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i        : write push_data_i at the tail
//   pop_i         : drop the head entry
//   flush_i       : empty the buffer (wins over push/pop)
//   head_o        : oldest entry
//   full_o/empty_o: occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  buf_entry_t push_data_i,
  output buf_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  buf_entry_t entry_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = pop_i && (count_q != 2'd0);
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign w_push = push_i && ((count_q != 2'd2) || w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q  <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        entry_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues in-order requests to the
//               instruction memory, buffers up to two responses and feeds the
//               IF/ID register, with stall/flush/redirect handling.
//               Optional performance counters are built when the macro
//               FETCH_PERF_CNT_EN is defined.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   imem             : instruction memory bus (master side)
//   stall_d_i        : hold IF/ID
//   flush_d_i        : bubble IF/ID
//   redirect_i/_pc_i : resolved control-flow change and its target
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o : IF/ID register
//   fetch_count_o, bubble_count_o : (FETCH_PERF_CNT_EN only) counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fetch_unit_if.master imem,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc_plus4_d_o,
  output logic        valid_d_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_f_q;     // next address to request
  logic [31:0]  rsp_pc_q;   // PC of the next response that will be kept
  logic [1:0]   outs_q;     // requests granted but not yet answered
  logic [1:0]   outs_d;
  logic [1:0]   discard_q;  // responses still to be dropped in DRAIN
  ifid_t        ifid_q;

  logic         w_req;
  logic         w_grant;
  logic         w_rsp;
  logic         w_rsp_keep;
  logic         w_ifid_load;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic         w_buf_full;
  logic         w_buf_empty;
  buf_entry_t   w_head;
  buf_entry_t   w_rsp_entry;

  // Outstanding + buffered must stay <= 2 so every response has a slot.
  assign w_req = (state_q == RUN) &&
                 (((outs_q == 2'd0) && !w_buf_full) ||
                  ((outs_q == 2'd1) && w_buf_empty));
  assign w_grant = w_req && imem.imem_gnt_i;

  // Only responses to our own requests count; anything else (e.g. a
  // request abandoned by reset) arrives while outs_q is zero.
  assign w_rsp      = imem.imem_rvalid_i && (outs_q != 2'd0);
  assign w_rsp_keep = w_rsp && (state_q == RUN) && !redirect_i;

  assign w_ifid_load = !stall_d_i && !flush_d_i && !redirect_i;
  assign w_pop       = w_ifid_load && !w_buf_empty;
  assign w_bypass    = w_ifid_load && w_buf_empty && w_rsp_keep;
  assign w_push      = w_rsp_keep && !w_bypass;

  assign w_rsp_entry.instr = imem.imem_rdata_i;
  assign w_rsp_entry.pc    = rsp_pc_q;

  always_comb begin
    outs_d = outs_q;
    case ({w_grant, w_rsp})
      2'b10:   outs_d = outs_q + 2'd1;
      2'b01:   outs_d = outs_q - 2'd1;
      default: outs_d = outs_q;
    endcase
  end

  fetch_buffer u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .flush_i     (redirect_i),
    .push_data_i (w_rsp_entry),
    .head_o      (w_head),
    .full_o      (w_buf_full),
    .empty_o     (w_buf_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= BOOT;
      pc_f_q    <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      outs_q    <= 2'd0;
      discard_q <= 2'd0;
      ifid_q    <= make_ifid(NOP_INSTR, 32'd0, 1'b0);
    end else begin
      outs_q <= outs_d;
      if (w_grant) begin
        pc_f_q <= pc_f_q + 32'd4;
      end
      if (w_rsp_keep) begin
        rsp_pc_q <= rsp_pc_q + 32'd4;
      end

      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     state_q <= RUN;
        DRAIN: begin
          if (w_rsp) begin
            discard_q <= discard_q - 2'd1;
            if (discard_q == 2'd1) begin
              state_q <= RUN;
            end
          end
        end
        default: state_q <= BOOT;
      endcase

      // Every request still in flight after this edge was issued on the
      // old path, including one granted in this very cycle.
      if (redirect_i) begin
        pc_f_q    <= redirect_pc_i;
        rsp_pc_q  <= redirect_pc_i;
        discard_q <= outs_d;
        state_q   <= (outs_d != 2'd0) ? DRAIN : RUN;
      end

      if (redirect_i || flush_d_i) begin
        ifid_q <= make_ifid(NOP_INSTR, 32'd0, 1'b0);
      end else if (!stall_d_i) begin
        if (!w_buf_empty) begin
          ifid_q <= make_ifid(w_head.instr, w_head.pc, 1'b1);
        end else if (w_rsp_keep) begin
          ifid_q <= make_ifid(imem.imem_rdata_i, rsp_pc_q, 1'b1);
        end else begin
          ifid_q <= make_ifid(NOP_INSTR, 32'd0, 1'b0);
        end
      end
    end
  end

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = pc_f_q;

  assign instr_d_o    = ifid_q.instr;
  assign pc_d_o       = ifid_q.pc;
  assign pc_plus4_d_o = ifid_q.pc_plus4;
  assign valid_d_o    = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (ifid_q.valid && !stall_d_i) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!ifid_q.valid) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count_o  = fetch_cnt_q;
  assign bubble_count_o = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural memory
//               with programmable latency answers requests in order; the
//               reference model is the architectural instruction stream:
//               decode must see consecutive PCs from the last reset/redirect
//               target, each carrying the memory word of that address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d;
  logic        flush_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  fetch_unit_if imem_if ();

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (C_RESET_PC),
    .NOP_INSTR (C_NOP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem          (imem_if),
    .stall_d_i     (stall_d),
    .flush_d_i     (flush_d),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_d_o     (instr_d),
    .pc_d_o        (pc_d),
    .pc_plus4_d_o  (pc4_d),
    .valid_d_o     (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_o  (fetch_cnt),
    .bubble_count_o (bubble_cnt)
`endif
  );

  // ---------------- behavioural instruction memory ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t rq[$];
  int   cyc   = 0;
  int   lat   = 1;
  bit   ready = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_if.imem_rvalid_i === 1'b1) void'(rq.pop_front());
    if (imem_if.imem_req_o === 1'b1 && imem_if.imem_gnt_i === 1'b1)
      rq.push_back('{addr: imem_if.imem_addr_o, due: cyc + 1 + lat});
  end

  always @(negedge clk) begin
    imem_if.imem_gnt_i <= ready && (imem_if.imem_req_o === 1'b1);
    if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
      imem_if.imem_rvalid_i <= 1'b1;
      imem_if.imem_rdata_i  <= mem_word(rq[0].addr);
    end else begin
      imem_if.imem_rvalid_i <= 1'b0;
      imem_if.imem_rdata_i  <= 32'hDEAD_BEEF;
    end
  end

  // ---------------- checking ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  int          bubbles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. The instruction in decode leaves when it is consumed
  // (no stall) or killed (flush); a redirect or reset restarts the stream.
  task automatic tick();
    if (rst) exp_pc = C_RESET_PC;
    else if (redirect) exp_pc = redirect_pc;
    else if (valid_d === 1'b1 && (!stall_d || flush_d)) exp_pc = exp_pc + 32'd4;
    @(posedge clk);
    #1;
    if (valid_d === 1'b1) begin
      chk("stream_pc", pc_d, exp_pc);
      chk("stream_instr", instr_d, mem_word(exp_pc));
      chk("stream_pc4", pc4_d, exp_pc + 32'd4);
    end else begin
      chk("bubble_instr", instr_d, C_NOP);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (valid_d !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, valid_d}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; exp_pc = C_RESET_PC; lat = 1; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", instr_d, C_NOP);
    chk("rst_pc", pc_d, 32'd0);
    chk("rst_pc4", pc4_d, 32'd4);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_req", {31'd0, imem_if.imem_req_o}, 32'd0);

    // Zero-wait memory: BOOT cycle, request, response, then 1 instr/cycle.
    rst = 1'b0;
    chk("boot_req", {31'd0, imem_if.imem_req_o}, 32'd0);
    tick(); chk("run_req", {31'd0, imem_if.imem_req_o}, 32'd1);
    tick(); chk("pre_valid", {31'd0, valid_d}, 32'd0);
    tick(); chk("first_valid", {31'd0, valid_d}, 32'd1);
    chk("first_pc", pc_d, C_RESET_PC);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("zw_valid", {31'd0, valid_d}, 32'd1);
      chk("zw_pc", pc_d, 32'(i * 4));
    end

    // Stall three cycles at pc 0x10.
    stall_d = 1'b1;
    tick(); chk("stall_hold", pc_d, 32'h10);
    chk("stall_req_low", {31'd0, imem_if.imem_req_o}, 32'd0);
    tick(); chk("stall_hold", pc_d, 32'h10);
    chk("stall_req_low", {31'd0, imem_if.imem_req_o}, 32'd0);
    tick(); stall_d = 1'b0;
    chk("stall_hold", pc_d, 32'h10);
    tick(); chk("after_stall_pc", pc_d, 32'h14);
    tick(); chk("after_stall_pc", pc_d, 32'h18);
    tick(); chk("after_stall_pc", pc_d, 32'h1C);

    // Redirect with two requests in flight.
    lat = 3;
    n = 0;
    while (rq.size() != 2 && n < 20) begin tick(); n++; end
    chk("two_outstanding", 32'(rq.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("redirect_bubble", {31'd0, valid_d}, 32'd0);
    wait_valid("redirect_wait");
    chk("redirect_target", pc_d, 32'h100);

    // Slow memory produces bubbles but keeps order.
    bubbles = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_d !== 1'b1) bubbles++;
    end
    chk("lat3_bubbles", {31'd0, bubbles > 0}, 32'd1);

    // Flush together with stall.
    wait_valid("flush_wait");
    stall_d = 1'b1; flush_d = 1'b1;
    tick();
    stall_d = 1'b0; flush_d = 1'b0;
    chk("flush_instr", instr_d, C_NOP);
    chk("flush_valid", {31'd0, valid_d}, 32'd0);
    wait_valid("after_flush_wait");

    // PC wrap-around.
    lat = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    wait_valid("wrap_wait");
    chk("wrap_pc0", pc_d, 32'hFFFF_FFF8);
    tick(); wait_valid("wrap_wait");
    chk("wrap_pc1", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_d, 32'd0);
    tick(); wait_valid("wrap_wait");
    chk("wrap_pc2", pc_d, 32'd0);

    // Randomised traffic against the stream model.
    for (int i = 0; i < 400; i++) begin
      lat      = int'($urandom_range(1, 4));
      ready    = ($urandom_range(0, 3) != 0);
      stall_d  = ($urandom_range(0, 3) == 0);
      flush_d  = ($urandom_range(0, 15) == 0);
      redirect = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0;
      else redirect_pc = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0; ready = 1'b1;
    wait_valid("rand_tail_wait");

    // Reset with one request outstanding and its response arriving late.
    ready = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 60) begin tick(); n++; end
    chk("mem_idle", 32'(rq.size()), 32'd0);
    n = 0;
    while (imem_if.imem_req_o !== 1'b1 && n < 20) begin tick(); n++; end
    lat = 4; ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("one_outstanding", 32'(rq.size()), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", {31'd0, valid_d}, 32'd0);
    n = 0;
    while (rq.size() != 0 && n < 20) begin tick(); n++; end
    chk("late_rsp_gone", 32'(rq.size()), 32'd0);
    tick();
    chk("late_rsp_ignored", {31'd0, valid_d}, 32'd0);
    lat = 1; ready = 1'b1;
    wait_valid("restart_wait");
    chk("restart_pc", pc_d, C_RESET_PC);
    chk("restart_instr", instr_d, mem_word(C_RESET_PC));
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
